key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
- Sequences one combinational key_expansion instance over all AES-128 rounds, one round per clock.
- Stores the cipher key plus the 10 round keys in an internal round-key file.
- Exposes a start/done handshake to the pipeline controller and a 1-cycle-latency read port for the execute-stage AddRoundKey unit.
- Sits in executeStage beside the AES vector datapath.

Parameters:
- regSize, 32, width of one key word in bits
- vecSize, 4, words per round key (AES-128)
- NUM_ROUNDS, 10, number of expansion rounds; key file holds NUM_ROUNDS+1 entries

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new expansion; sampled only in IDLE
- key_in  input  [vecSize-1:0][regSize-1:0]  cipher key; word [0] = w0; sampled on accepted start
- busy  output  1  high in LOAD/EXPAND
- done  output  1  one-cycle pulse when round key NUM_ROUNDS is written
- keys_valid  output  1  high when all entries belong to the current key
- rd_en  input  1  read request
- rd_round  input  4  round-key index to read, 0..NUM_ROUNDS
- rd_key  output  [vecSize-1:0][regSize-1:0]  registered read data
- rd_valid  output  1  high the cycle after rd_en when the entry has been written since the last start
- rd_err  output  1  high the cycle after rd_en when rd_round > NUM_ROUNDS

Behaviour:
- Reset (async, rst_n=0): state=IDLE; round counter=0; busy=0, done=0, keys_valid=0, rd_valid=0, rd_err=0, rd_key=0; key-file contents cleared to 0; written-flag vector cleared.
- FSM states: IDLE, LOAD, EXPAND, FINISH.
- IDLE:
  - start=1 latches key_in into a staging register, clears keys_valid and all written flags, and moves to LOAD.
  - start is ignored in every other state; no queuing.
- LOAD (1 cycle): writes the staging key to entry 0, sets written[0], sets cnt=0, moves to EXPAND.
- EXPAND:
  - Drives key_expansion with current_key = entry cnt and round = cnt. rcon index 0 produces round key 1.
  - Each cycle writes next_key to entry cnt+1, sets written[cnt+1], and increments cnt.
  - When cnt=NUM_ROUNDS-1 is written, moves to FINISH.
- FINISH (1 cycle): done=1, keys_valid=1, then IDLE.
- Latency: start accepted at edge E0; entry 0 written at E1; entry r written at E1+r; done high during the cycle after E1+NUM_ROUNDS. Total 12 cycles start-to-done for defaults, including FINISH.
- A new start after done regenerates all entries. keys_valid drops the cycle after the start is accepted.
- Read port:
  - Read is registered; rd_key updates one cycle after rd_en.
  - When rd_en=0, rd_valid=0 and rd_err=0, and rd_key holds its last value.
  - Out-of-range index: rd_key=0, rd_valid=0, rd_err=1.
  - In-range but not yet written: rd_key returns the stored (stale or zero) data with rd_valid=0.
- Read/write same entry in the same cycle: read returns the old value (write-after-read); rd_valid follows the old written flag.
- Reset mid-expansion: all state and the key file clear immediately; no done pulse.
- Counter width: ceil(log2(NUM_ROUNDS+1)) bits, minimum 4. The counter never wraps because the FSM exits at NUM_ROUNDS-1.

Optional Feature:
- KEY_SCHED_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD or EXPAND returns to IDLE at the next edge with busy=0, no done pulse, and keys_valid=0. Written flags are retained, so partially produced entries still read with rd_valid=1.
  - abort in IDLE/FINISH is ignored. abort and start in the same IDLE cycle: start wins.
- Not defined: no abort port; an expansion always runs to completion or reset.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> all outputs 0; rd_en with rd_round=0 -> rd_valid=0, rd_key=0.
- FIPS-197 key: key_in = {09cf4f3c, abf71588, 28aed2a6, 2b7e1516} (word[0] = 2b7e1516), start 1 cycle -> busy 11 cycles, done pulse 12 cycles after start. Entry 1 = a0fafe17 88542cb1 23a33939 2a6c7605; entry 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; keys_valid=1.
- Read during expansion: rd_round=3 polled every cycle -> rd_valid rises exactly the cycle after entry 3 is written. rd_round=11 -> rd_err=1, rd_key=0.
- Start while busy: second start with a different key at cycle 5 -> ignored; final keys match the first key; exactly one done pulse.
- Async reset mid-run: rst_n low asynchronously at cycle 6 -> busy/keys_valid drop without a clock edge, no done; a restart with the same key gives correct entry 10.
- KEY_SCHED_ABORT_EN: abort at cycle 4 -> IDLE, no done, keys_valid=0; entries 0..2 read rd_valid=1, entry 5 reads rd_valid=0.

Source files
------------

// File: rtl/key_schedule_ctrl_if.sv
// Handshake and read-port bundle for key_schedule_ctrl.
// The abort port exists only when KEY_SCHED_ABORT_EN is defined.
interface key_schedule_ctrl_if #(
  parameter int regSize = 32,
  parameter int vecSize = 4
);
  logic                             start;
  logic [vecSize-1:0][regSize-1:0]  key_in;
  logic                             busy;
  logic                             done;
  logic                             keys_valid;
  logic                             rd_en;
  logic [3:0]                       rd_round;
  logic [vecSize-1:0][regSize-1:0]  rd_key;
  logic                             rd_valid;
  logic                             rd_err;
`ifdef KEY_SCHED_ABORT_EN
  logic                             abort;

  modport master (
    output start, key_in, rd_en, rd_round, abort,
    input  busy, done, keys_valid, rd_key, rd_valid, rd_err
  );
  modport slave (
    input  start, key_in, rd_en, rd_round, abort,
    output busy, done, keys_valid, rd_key, rd_valid, rd_err
  );
`else
  modport master (
    output start, key_in, rd_en, rd_round,
    input  busy, done, keys_valid, rd_key, rd_valid, rd_err
  );
  modport slave (
    input  start, key_in, rd_en, rd_round,
    output busy, done, keys_valid, rd_key, rd_valid, rd_err
  );
`endif
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer: one key_expansion round per clock into an
// 11-entry round-key file with a registered read port. KEY_SCHED_ABORT_EN adds abort.
module key_expansion #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] current_key,
  input  logic [3:0]                      round,
  output logic [vecSize-1:0][regSize-1:0] next_key
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = b;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [regSize-1:0] rot_w;
  logic [regSize-1:0] temp_w;

  always_comb begin
    rot_w    = {current_key[vecSize-1][23:0], current_key[vecSize-1][31:24]};
    temp_w   = {sbox(rot_w[31:24]) ^ rcon(round), sbox(rot_w[23:16]),
                sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    next_key = '0;
    next_key[0] = current_key[0] ^ temp_w;
    for (int unsigned i = 1; i < vecSize; i++)
      next_key[i] = next_key[i-1] ^ current_key[i];
  end
endmodule

module key_schedule_ctrl #(
  parameter int regSize    = 32,
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_schedule_ctrl_if.slave   bus
);
  localparam int CNT_W = ($clog2(NUM_ROUNDS + 1) > 4) ? $clog2(NUM_ROUNDS + 1) : 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] EXPAND = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  typedef logic [vecSize-1:0][regSize-1:0] key_t;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  key_t              staging;
  key_t              kfile [NUM_ROUNDS+1];
  logic [NUM_ROUNDS:0] written;
  logic              keys_valid_q;
  key_t              next_key;
  key_t              rd_key_q;
  logic              rd_valid_q;
  logic              rd_err_q;
  logic              abort_req;

`ifdef KEY_SCHED_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign cnt_nxt = cnt + CNT_W'(1);

  key_expansion #(.regSize(regSize), .vecSize(vecSize)) u_key_expansion (
    .current_key (kfile[cnt]),
    .round       (cnt[3:0]),
    .next_key    (next_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      staging      <= '0;
      written      <= '0;
      keys_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_ROUNDS + 1; i++) kfile[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          staging      <= bus.key_in;
          keys_valid_q <= 1'b0;
          written      <= '0;
          state        <= LOAD;
        end
        LOAD: if (abort_req) begin
          state    <= IDLE;
        end else begin
          kfile[0]   <= staging;
          written[0] <= 1'b1;
          cnt        <= '0;
          state      <= EXPAND;
        end
        EXPAND: if (abort_req) begin
          state <= IDLE;
        end else begin
          kfile[cnt_nxt]   <= next_key;
          written[cnt_nxt] <= 1'b1;
          cnt              <= cnt_nxt;
          if (cnt == CNT_W'(NUM_ROUNDS - 1)) begin
            state        <= FINISH;
            keys_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-blocking reads of kfile/written give write-after-read on a same-entry collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else if (bus.rd_en) begin
      if (bus.rd_round > 4'(NUM_ROUNDS)) begin
        rd_key_q   <= '0;
        rd_valid_q <= 1'b0;
        rd_err_q   <= 1'b1;
      end else begin
        rd_key_q   <= kfile[bus.rd_round];
        rd_valid_q <= written[bus.rd_round];
        rd_err_q   <= 1'b0;
      end
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end
  end

  assign bus.busy       = (state == LOAD) || (state == EXPAND);
  assign bus.done       = (state == FINISH);
  assign bus.keys_valid = keys_valid_q;
  assign bus.rd_key     = rd_key_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_err     = rd_err_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using the FIPS-197 AES-128 example key.
// Abort sequence is built only when KEY_SCHED_ABORT_EN is defined.
module tb_key_schedule_ctrl;
  typedef logic [3:0][31:0] key_t;
  typedef struct {
    logic       rd_en;
    logic [3:0] rd_round;
    logic       exp_valid;
    logic       exp_err;
    key_t       exp_key;
  } vec_t;

  localparam key_t K0  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam key_t K1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam key_t K2  = {32'h7359f67f, 32'h5935807a, 32'h7a96b943, 32'hf2c295f2};
  localparam key_t K10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam key_t KB  = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  key_schedule_ctrl_if #(.regSize(32), .vecSize(4)) bus ();

  key_schedule_ctrl #(.regSize(32), .vecSize(4), .NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic read_entry(input logic [3:0] idx, output key_t key, output logic valid);
    bus.rd_en    = 1'b1;
    bus.rd_round = idx;
    step();
    key   = bus.rd_key;
    valid = bus.rd_valid;
    bus.rd_en = 1'b0;
  endtask

  vec_t vecs [9];
  key_t rk;
  logic rv;
  int   busy_cnt, done_cnt, done_cyc, first_valid, kv_bad;

  initial begin
    vecs[0] = '{1'b1, 4'd0,  1'b1, 1'b0, K0};
    vecs[1] = '{1'b1, 4'd1,  1'b1, 1'b0, K1};
    vecs[2] = '{1'b1, 4'd2,  1'b1, 1'b0, K2};
    vecs[3] = '{1'b1, 4'd10, 1'b1, 1'b0, K10};
    vecs[4] = '{1'b1, 4'd11, 1'b0, 1'b1, '0};
    vecs[5] = '{1'b0, 4'd3,  1'b0, 1'b0, '0};
    vecs[6] = '{1'b1, 4'd10, 1'b1, 1'b0, K10};
    vecs[7] = '{1'b0, 4'd0,  1'b0, 1'b0, K10};
    vecs[8] = '{1'b1, 4'd15, 1'b0, 1'b1, '0};

    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rd_en = 1'b0;
    bus.rd_round = '0;
`ifdef KEY_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_keys_valid", bus.keys_valid, 1'b0);
    chk("reset_rd_valid", bus.rd_valid, 1'b0);
    chk("reset_rd_err", bus.rd_err, 1'b0);
    read_entry(4'd0, rk, rv);
    chk("reset_read0_valid", rv, 1'b0);
    chk("reset_read0_key", rk, '0);

    // FIPS-197 expansion with entry 3 polled each cycle
    bus.key_in = K0;
    bus.start = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_round = 4'd3;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; first_valid = 0; kv_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.keys_valid) kv_bad++;
      if (bus.done) begin done_cnt++; done_cyc = k; end
      if (bus.rd_valid && first_valid == 0) first_valid = k;
      if (k == 12) chk("fips_keys_valid_at_done", bus.keys_valid, 1'b1);
    end
    bus.rd_en = 1'b0;
    chk("fips_busy_cycles", 128'(busy_cnt), 128'd11);
    chk("fips_done_count", 128'(done_cnt), 128'd1);
    chk("fips_done_cycle", 128'(done_cyc), 128'd12);
    chk("fips_rd3_first_valid", 128'(first_valid), 128'd6);
    chk("fips_keys_valid_low_busy", 128'(kv_bad), 128'd0);

    for (int i = 0; i < 9; i++) begin
      bus.rd_en = vecs[i].rd_en;
      bus.rd_round = vecs[i].rd_round;
      step();
      chk($sformatf("vec%0d_key", i), bus.rd_key, vecs[i].exp_key);
      chk($sformatf("vec%0d_valid", i), bus.rd_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_err", i), bus.rd_err, vecs[i].exp_err);
    end
    bus.rd_en = 1'b0;

    // Start while busy is ignored
    bus.key_in = K0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_keys_valid_drop", bus.keys_valid, 1'b0);
    done_cnt = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (bus.done) done_cnt++;
      if (k == 4) begin bus.key_in = KB; bus.start = 1'b1; end
      else bus.start = 1'b0;
    end
    chk("busy_start_done_count", 128'(done_cnt), 128'd1);
    read_entry(4'd10, rk, rv);
    chk("busy_start_entry10", rk, K10);
    read_entry(4'd1, rk, rv);
    chk("busy_start_entry1", rk, K1);

    // Asynchronous reset mid-expansion
    bus.key_in = K0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    done_cnt = 0;
    for (int k = 2; k <= 6; k++) begin
      step();
      if (bus.done) done_cnt++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", bus.busy, 1'b0);
    chk("async_done", bus.done, 1'b0);
    chk("async_keys_valid", bus.keys_valid, 1'b0);
    chk("async_no_done_before", 128'(done_cnt), 128'd0);
    step();
    step();
    rst_n = 1'b1;
    read_entry(4'd10, rk, rv);
    chk("async_entry10_cleared", rk, '0);
    chk("async_entry10_invalid", rv, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    done_cnt = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (bus.done) done_cnt++;
    end
    chk("rerun_done_count", 128'(done_cnt), 128'd1);
    read_entry(4'd10, rk, rv);
    chk("rerun_entry10", rk, K10);
    chk("rerun_entry10_valid", rv, 1'b1);

`ifdef KEY_SCHED_ABORT_EN
    // Abort after entry 2 has been written
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 2; k <= 4; k++) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (bus.done) done_cnt++;
    end
    chk("abort_done_count", 128'(done_cnt), 128'd0);
    chk("abort_keys_valid", bus.keys_valid, 1'b0);
    for (int e = 0; e <= 2; e++) begin
      read_entry(4'(e), rk, rv);
      chk($sformatf("abort_entry%0d_valid", e), rv, 1'b1);
    end
    chk("abort_entry2_key", rk, K2);
    read_entry(4'd5, rk, rv);
    chk("abort_entry5_valid", rv, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
